// File: rtl/nubus_pkg.sv
// Shared constants for the NuBus slave controller: ACK status codes, FSM
// encoding, slot-space nibbles and the byte-lane strobe helper.
package nubus_pkg;

  typedef logic [1:0] nub_status_t;

  localparam nub_status_t ST_COMPLETE = 2'b00;
  localparam nub_status_t ST_ERROR    = 2'b01;
  localparam nub_status_t ST_TIMEOUT  = 2'b10;
  localparam nub_status_t ST_TRYAGAIN = 2'b11;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_ACK    = 2'd2;

  localparam logic [3:0] SLOTS_NIBBLE = 4'hF;
  localparam logic [3:0] SUPER_MIN    = 4'h9;
  localparam logic [3:0] SUPER_MAX    = 4'hE;

  // tm0n low selects a single byte; otherwise addr[1:0] picks word/half, 10 is reserved
  function automatic logic [3:0] lane_strobe(input logic tm0n, input logic [1:0] lane);
    logic [3:0] s;
    if (!tm0n) begin
      s = 4'b0001 << lane;
    end else begin
      case (lane)
        2'b00:   s = 4'b1111;
        2'b01:   s = 4'b0011;
        2'b11:   s = 4'b1100;
        default: s = 4'b0000;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/nubus_addr_decode.sv
// Combinational NuBus address decoder: slot, superslot and NUM_WIN mask/base
// windows, reduced to a one-hot vector with slot > super > window 0 > ... priority.
module nubus_addr_decode
  import nubus_pkg::*;
#(
  parameter int                     NUM_WIN      = 2,
  parameter logic [NUM_WIN*32-1:0]  WIN_BASE     = {32'h0000_0000, 32'h1000_0000},
  parameter logic [NUM_WIN*32-1:0]  WIN_MASK     = {32'hF000_0000, 32'hF000_0000},
  parameter int                     STD_SLOT_EN  = 1,
  parameter int                     STD_SUPER_EN = 1
) (
  input  logic [31:0]        i_addr,
  input  logic [3:0]         i_id,
  output logic [NUM_WIN+1:0] o_hit
);

  logic [NUM_WIN+1:0] w_raw;

  assign w_raw[0] = (STD_SLOT_EN != 0) && (i_addr[31:28] == SLOTS_NIBBLE)
                    && (i_addr[27:24] == i_id);
  assign w_raw[1] = (STD_SUPER_EN != 0) && (i_addr[31:28] == i_id)
                    && (i_id >= SUPER_MIN) && (i_id <= SUPER_MAX);

  for (genvar gi = 0; gi < NUM_WIN; gi++) begin : g_win
    assign w_raw[gi+2] = (i_addr & WIN_MASK[32*gi +: 32]) == WIN_BASE[32*gi +: 32];
  end

  // isolate the lowest set bit, which is the highest-priority hit
  assign o_hit = w_raw & (~w_raw + 1'b1);

endmodule

// File: rtl/nubus_slave_ctrl.sv
// NuBus slave controller: decodes a START, runs one memory access and drives the
// ACK cycle with status and read data. Optional TRYAGAIN: NUBUS_SLV_TRYAGAIN_EN.
module nubus_slave_ctrl
  import nubus_pkg::*;
#(
  parameter int                     NUM_WIN        = 2,
  parameter logic [NUM_WIN*32-1:0]  WIN_BASE       = {32'h0000_0000, 32'h1000_0000},
  parameter logic [NUM_WIN*32-1:0]  WIN_MASK       = {32'hF000_0000, 32'hF000_0000},
  parameter int                     STD_SLOT_EN    = 1,
  parameter int                     STD_SUPER_EN   = 1,
  parameter int                     TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               nub_startn,
  input  logic               nub_ackn,
  input  logic               nub_tm1n,
  input  logic               nub_tm0n,
  input  logic [31:0]        nub_adn,
  input  logic [3:0]         nub_idn,
  input  logic               mem_ready,
  input  logic               mem_err,
  input  logic [31:0]        mem_rdata,
`ifdef NUBUS_SLV_TRYAGAIN_EN
  input  logic               mem_busy,
`endif
  output logic               slv_ackn_o,
  output logic               slv_tm1n_o,
  output logic               slv_tm0n_o,
  output logic [31:0]        slv_ad_o,
  output logic               slv_ad_oe_o,
  output logic               slv_busy_o,
  output logic               mem_valid_o,
  output logic [3:0]         mem_write_o,
  output logic [31:0]        mem_addr_o,
  output logic [31:0]        mem_wdata_o,
  output logic [NUM_WIN+1:0] mem_win_o
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]         r_state;
  logic [15:0]        r_cnt;
  logic               r_write;
  logic [3:0]         r_strb;
  logic [31:0]        r_addr;
  logic [NUM_WIN+1:0] r_win;
  logic               r_valid;
  logic               r_ackn;
  logic               r_tm1n;
  logic               r_tm0n;
  logic               r_oe;
  logic [31:0]        r_ad;

  logic [31:0]        w_addr;
  logic [NUM_WIN+1:0] w_hit;
  logic               w_start;
  logic               w_reserved;
  logic               w_mem_busy;
  logic               w_ack_go;
  nub_status_t        w_ack_st;

  assign w_addr     = ~nub_adn;
  assign w_start    = ~nub_startn & nub_ackn;
  assign w_reserved = ~nub_tm1n & nub_tm0n & (w_addr[1:0] == 2'b10);
`ifdef NUBUS_SLV_TRYAGAIN_EN
  assign w_mem_busy = mem_busy;
`else
  assign w_mem_busy = 1'b0;
`endif

  nubus_addr_decode #(
    .NUM_WIN      (NUM_WIN),
    .WIN_BASE     (WIN_BASE),
    .WIN_MASK     (WIN_MASK),
    .STD_SLOT_EN  (STD_SLOT_EN),
    .STD_SUPER_EN (STD_SUPER_EN)
  ) u_decode (
    .i_addr (w_addr),
    .i_id   (~nub_idn),
    .o_hit  (w_hit)
  );

  // Every path into ACK: reserved/busy straight from IDLE, ready or timeout from ACCESS
  always_comb begin
    w_ack_go = 1'b0;
    w_ack_st = ST_COMPLETE;
    case (r_state)
      S_IDLE: begin
        if (w_start && (|w_hit)) begin
          if (w_reserved) begin
            w_ack_go = 1'b1;
            w_ack_st = ST_ERROR;
          end else if (w_mem_busy) begin
            w_ack_go = 1'b1;
            w_ack_st = ST_TRYAGAIN;
          end
        end
      end
      S_ACCESS: begin
        if (mem_ready) begin
          w_ack_go = 1'b1;
          w_ack_st = mem_err ? ST_ERROR : ST_COMPLETE;
        end else if (r_cnt == TO_LAST) begin
          w_ack_go = 1'b1;
          w_ack_st = ST_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_strb  <= '0;
      r_addr  <= '0;
      r_win   <= '0;
      r_valid <= 1'b0;
      r_ackn  <= 1'b1;
      r_tm1n  <= 1'b1;
      r_tm0n  <= 1'b1;
      r_oe    <= 1'b0;
      r_ad    <= '1;
    end else begin
      r_ackn <= 1'b1;
      r_tm1n <= 1'b1;
      r_tm0n <= 1'b1;
      r_oe   <= 1'b0;
      r_ad   <= '1;
      if (r_state == S_IDLE && w_start) begin
        r_addr  <= w_addr;
        r_write <= ~nub_tm1n;
        r_strb  <= nub_tm1n ? 4'b0000 : lane_strobe(nub_tm0n, w_addr[1:0]);
        r_win   <= w_hit;
      end
      if (w_ack_go) begin
        r_state          <= S_ACK;
        r_valid          <= 1'b0;
        r_ackn           <= 1'b0;
        {r_tm1n, r_tm0n} <= ~w_ack_st;
        // COMPLETE only arises from ACCESS, so r_write is the latched direction here
        if (w_ack_st == ST_COMPLETE && !r_write) begin
          r_oe <= 1'b1;
          r_ad <= ~mem_rdata;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start && (|w_hit)) begin
              r_state <= S_ACCESS;
              r_valid <= 1'b1;
              r_cnt   <= '0;
            end
          end
          S_ACCESS: r_cnt   <= r_cnt + 16'd1;
          default:  r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign slv_ackn_o  = r_ackn;
  assign slv_tm1n_o  = r_tm1n;
  assign slv_tm0n_o  = r_tm0n;
  assign slv_ad_o    = r_ad;
  assign slv_ad_oe_o = r_oe;
  assign slv_busy_o  = (r_state != S_IDLE);
  assign mem_valid_o = r_valid;
  assign mem_write_o = r_valid ? r_strb : 4'b0000;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = ~nub_adn;
  assign mem_win_o   = r_win;

endmodule

// File: tb/tb_nubus_slave_ctrl.sv
// Self-checking bench for nubus_slave_ctrl: directed scenarios with literal
// expectations, then random traffic checked each cycle against a transaction model.
module tb_nubus_slave_ctrl;

  localparam int NW = 2;
  localparam logic [NW*32-1:0] WB = {32'h0000_0000, 32'h1000_0000};
  localparam logic [NW*32-1:0] WM = {32'hF000_0000, 32'hF000_0000};
  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic nub_startn, nub_ackn, nub_tm1n, nub_tm0n;
  logic [31:0] nub_adn;
  logic [3:0]  nub_idn;
  logic mem_ready, mem_err, mem_busy;
  logic [31:0] mem_rdata;

  logic slv_ackn_o, slv_tm1n_o, slv_tm0n_o, slv_ad_oe_o, slv_busy_o, mem_valid_o;
  logic [31:0] slv_ad_o, mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_write_o;
  logic [NW+1:0] mem_win_o;

  int tests = 0;
  int fails = 0;

  // Transaction-level model state
  bit          m_access, m_ack, m_wr, m_oe;
  int          m_age;
  logic [1:0]  m_st;
  logic [3:0]  m_strb;
  logic [31:0] m_addr, m_rd;
  logic [NW+1:0] m_win;

  always #5 clk = ~clk;

  nubus_slave_ctrl #(
    .NUM_WIN(NW), .WIN_BASE(WB), .WIN_MASK(WM),
    .STD_SLOT_EN(1), .STD_SUPER_EN(1), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .nub_startn(nub_startn), .nub_ackn(nub_ackn),
    .nub_tm1n(nub_tm1n), .nub_tm0n(nub_tm0n),
    .nub_adn(nub_adn), .nub_idn(nub_idn),
    .mem_ready(mem_ready), .mem_err(mem_err), .mem_rdata(mem_rdata),
`ifdef NUBUS_SLV_TRYAGAIN_EN
    .mem_busy(mem_busy),
`endif
    .slv_ackn_o(slv_ackn_o), .slv_tm1n_o(slv_tm1n_o), .slv_tm0n_o(slv_tm0n_o),
    .slv_ad_o(slv_ad_o), .slv_ad_oe_o(slv_ad_oe_o), .slv_busy_o(slv_busy_o),
    .mem_valid_o(mem_valid_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_win_o(mem_win_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NW+1:0] ref_decode(input logic [31:0] a, input logic [3:0] id);
    logic [NW+1:0] r;
    int idx;
    idx = -1;
    if (a[31:28] == 4'hF && a[27:24] == id) idx = 0;
    else if (a[31:28] == id && id >= 4'h9 && id <= 4'hE) idx = 1;
    else
      for (int i = 0; i < NW; i++)
        if (idx < 0 && (a & WM[32*i +: 32]) == WB[32*i +: 32]) idx = i + 2;
    r = '0;
    if (idx >= 0) r[idx] = 1'b1;
    return r;
  endfunction

  function automatic logic [3:0] ref_strobe(input bit byte_mode, input logic [1:0] a);
    if (byte_mode) return 4'b0001 << a;
    case (a)
      2'b00:   return 4'b1111;
      2'b01:   return 4'b0011;
      2'b11:   return 4'b1100;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic model_reset();
    m_access = 0; m_ack = 0; m_wr = 0; m_oe = 0; m_age = 0;
    m_st = 2'b00; m_strb = '0; m_addr = '0; m_rd = '0; m_win = '0;
  endtask

  task automatic give_ack(input logic [1:0] st, input bit oe);
    m_access = 0; m_ack = 1; m_st = st; m_oe = oe; m_rd = mem_rdata;
    $display("[TB] txn addr=%h status=%0d", m_addr, st);
  endtask

  // Applies the rules to the inputs present at one rising edge
  task automatic model_edge();
    if (m_ack) begin
      m_ack = 0;
    end else if (m_access) begin
      if (mem_ready) give_ack(mem_err ? 2'b01 : 2'b00, !m_wr && !mem_err);
      else if (m_age == TO - 1) give_ack(2'b10, 0);
      else m_age++;
    end else if (!nub_startn && nub_ackn) begin
      m_addr = ~nub_adn;
      m_wr   = !nub_tm1n;
      m_strb = m_wr ? ref_strobe(!nub_tm0n, m_addr[1:0]) : 4'b0000;
      m_win  = ref_decode(m_addr, ~nub_idn);
      if (m_win != 0) begin
        if (m_wr && nub_tm0n && m_addr[1:0] == 2'b10) give_ack(2'b01, 0);
`ifdef NUBUS_SLV_TRYAGAIN_EN
        else if (mem_busy) give_ack(2'b11, 0);
`endif
        else begin
          m_access = 1;
          m_age = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [1:0]  e_tm;
    logic [31:0] e_ad;
    logic [3:0]  e_wr;
    e_tm = m_ack ? ~m_st : 2'b11;
    e_ad = (m_ack && m_oe) ? ~m_rd : 32'hFFFF_FFFF;
    e_wr = m_access ? m_strb : 4'b0000;
    chk("ackn",  {31'd0, slv_ackn_o}, {31'd0, !m_ack});
    chk("tm",    {30'd0, slv_tm1n_o, slv_tm0n_o}, {30'd0, e_tm});
    chk("ad",    slv_ad_o, e_ad);
    chk("ad_oe", {31'd0, slv_ad_oe_o}, {31'd0, m_ack && m_oe});
    chk("busy",  {31'd0, slv_busy_o}, {31'd0, m_ack || m_access});
    chk("valid", {31'd0, mem_valid_o}, {31'd0, m_access});
    chk("write", {28'd0, mem_write_o}, {28'd0, e_wr});
    chk("addr",  mem_addr_o, m_addr);
    chk("win",   {{(30-NW){1'b0}}, mem_win_o}, {{(30-NW){1'b0}}, m_win});
    chk("wdata", mem_wdata_o, ~nub_adn);
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    nub_startn = 1; nub_ackn = 1; mem_ready = 0; mem_err = 0; mem_busy = 0;
  endtask

  task automatic start(input logic [31:0] a, input bit wr, input bit tm0n);
    nub_startn = 0; nub_ackn = 1; nub_adn = ~a; nub_tm1n = !wr; nub_tm0n = tm0n;
  endtask

  function automatic logic [31:0] rand_addr(input logic [3:0] id);
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(3))
      0: r[31:24] = {4'hF, id};
      1: r[31:28] = id;
      2: r[31:29] = 3'b000;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    logic [3:0] ids [5];
    ids[0] = 4'h9; ids[1] = 4'hB; ids[2] = 4'hE; ids[3] = 4'hF; ids[4] = 4'h3;
    idle_inputs();
    nub_tm1n = 1; nub_tm0n = 1; nub_adn = '1; nub_idn = 4'h4; mem_rdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    chk("rst_ackn", {31'd0, slv_ackn_o}, 32'd1);
    chk("rst_ad", slv_ad_o, 32'hFFFF_FFFF);
    chk("rst_win", {28'd0, mem_win_o}, 32'd0);
    reset = 0;

    // Slot read with minimum latency
    start(32'hFB00_0010, 0, 1);
    step();
    chk("slot_valid", {31'd0, mem_valid_o}, 32'd1);
    chk("slot_win", {28'd0, mem_win_o}, 32'b0001);
    idle_inputs(); mem_ready = 1; mem_rdata = 32'hDEAD_BEEF;
    step();
    chk("slot_ackn", {31'd0, slv_ackn_o}, 32'd0);
    chk("slot_tm", {30'd0, slv_tm1n_o, slv_tm0n_o}, 32'b11);
    chk("slot_ad", slv_ad_o, 32'h2152_4110);
    chk("slot_oe", {31'd0, slv_ad_oe_o}, 32'd1);
    idle_inputs();
    step();
    chk("slot_oe_off", {31'd0, slv_ad_oe_o}, 32'd0);

    // Superslot byte write finishing with an error
    start(32'hB000_0003, 1, 0);
    step();
    chk("super_win", {28'd0, mem_win_o}, 32'b0010);
    chk("super_wr", {28'd0, mem_write_o}, 32'b1000);
    idle_inputs(); mem_ready = 1; mem_err = 1;
    step();
    chk("super_tm", {30'd0, slv_tm1n_o, slv_tm0n_o}, 32'b10);
    idle_inputs();
    step();

    // Reserved write size goes straight to ACK with ERROR
    start(32'h1000_0002, 1, 1);
    step();
    chk("rsv_ackn", {31'd0, slv_ackn_o}, 32'd0);
    chk("rsv_valid", {31'd0, mem_valid_o}, 32'd0);
    chk("rsv_tm", {30'd0, slv_tm1n_o, slv_tm0n_o}, 32'b10);
    idle_inputs();
    step();

    // Timeout after TO access cycles
    start(32'hFB00_0000, 0, 1);
    step();
    idle_inputs();
    for (int k = 0; k < TO - 1; k++) begin
      step();
      chk("to_wait", {31'd0, slv_ackn_o}, 32'd1);
    end
    step();
    chk("to_ackn", {31'd0, slv_ackn_o}, 32'd0);
    chk("to_tm", {30'd0, slv_tm1n_o, slv_tm0n_o}, 32'b01);
    step();

    // Ready on the final access cycle beats the timeout
    start(32'hFB00_0004, 0, 1);
    step();
    idle_inputs();
    for (int k = 0; k < TO - 1; k++) step();
    mem_ready = 1; mem_rdata = 32'h0000_00FF;
    step();
    chk("race_tm", {30'd0, slv_tm1n_o, slv_tm0n_o}, 32'b11);
    chk("race_ad", slv_ad_o, 32'hFFFF_FF00);
    idle_inputs();
    step();

    // Reset in ACCESS releases everything and no ACK follows
    start(32'hFB00_0008, 0, 1);
    step();
    idle_inputs();
    reset = 1; model_reset();
    #1 compare_all();
    chk("rstmid_valid", {31'd0, mem_valid_o}, 32'd0);
    reset = 0;
    mem_ready = 1;
    step();
    chk("rstmid_ackn", {31'd0, slv_ackn_o}, 32'd1);
    idle_inputs();

    // START while busy and attention cycles are ignored
    start(32'hFB00_0010, 0, 1);
    step();
    start(32'h1000_0000, 0, 1);
    step();
    chk("busy_addr", mem_addr_o, 32'hFB00_0010);
    idle_inputs(); mem_ready = 1;
    step();
    idle_inputs();
    step();
    start(32'hFB00_0020, 0, 1); nub_ackn = 0;
    step();
    chk("attn_busy", {31'd0, slv_busy_o}, 32'd0);
    chk("attn_addr", mem_addr_o, 32'hFB00_0010);
    idle_inputs();

`ifdef NUBUS_SLV_TRYAGAIN_EN
    start(32'hFB00_0010, 0, 1); mem_busy = 1;
    step();
    chk("try_ackn", {31'd0, slv_ackn_o}, 32'd0);
    chk("try_tm", {30'd0, slv_tm1n_o, slv_tm0n_o}, 32'b00);
    chk("try_valid", {31'd0, mem_valid_o}, 32'd0);
    idle_inputs();
    step();
`endif

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      nub_startn = ($urandom_range(99) >= 30);
      nub_ackn   = ($urandom_range(99) >= 15);
      nub_tm1n   = 1'($urandom_range(1));
      nub_tm0n   = 1'($urandom_range(1));
      nub_idn    = ~ids[$urandom_range(4)];
      nub_adn    = ~rand_addr(~nub_idn);
      mem_ready  = ($urandom_range(99) < 35);
      mem_err    = ($urandom_range(99) < 25);
      mem_busy   = ($urandom_range(99) < 20);
      mem_rdata  = $urandom;
      if ($urandom_range(299) == 0) begin
        reset = 1; model_reset();
        #1 compare_all();
        reset = 0;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
